hdc_bundle_encoder: RTL

Parametrised streaming successor to the 4k baseline HDC encoder. Per sample it generates the position hypervector P from an internal LFSR compared against a scalar, and XOR-binds P with a level hypervector L streamed in W-bit beats. It accumulates the bound vector into D saturating bundle counters, then on request streams out the thresholded (majority) binary class hypervector and clears itself. It sits between the level-vector generator (random-flip stage) and the associative memory.

---
 rtl/hdc_bundle_encoder.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/hdc_bundle_encoder.sv
// Streaming HDC bundle encoder.
// Each sample builds a position vector P by comparing LFSR states against a
// scalar, binds P with the streamed level vector L, and adds the result into
// D saturating counters. A finalize request streams out the majority
// (thresholded) class vector, then zeroes the counters one row per cycle.

// One counter column: one counter per beat row for a single bit lane.
module hdc_lane #(
  parameter int ROWS  = 64,
  parameter int CNT_W = 8,
  parameter int BW    = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [BW-1:0]    row,
  input  logic             inc_en,
  input  logic             inc,
  input  logic             clr_en,
  input  logic [CNT_W-1:0] thr,
  output logic             bit_out
);
  logic [CNT_W-1:0] mem [ROWS];
  logic [CNT_W-1:0] cur;

  assign cur     = mem[row];
  assign bit_out = cur > thr;

  // Saturating read-modify-write of the addressed row, or a row clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) mem[r] <= '0;
    end else if (clr_en) begin
      mem[row] <= '0;
    end else if (inc_en && inc && (cur != {CNT_W{1'b1}})) begin
      mem[row] <= cur + CNT_W'(1);
    end
  end
endmodule

module hdc_bundle_encoder #(
  parameter int D      = 4096,
  parameter int W      = 64,
  parameter int CNT_W  = 8,
  parameter int SEED_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [SEED_W-1:0] cfg_seed,
  input  logic [SEED_W:0]   in_scalar,
  input  logic [W-1:0]      in_level,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              fin_req,
  output logic              fin_ack,
  output logic [W-1:0]      out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  n_samples
);
  localparam int ROWS = D / W;
  localparam int BW   = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                     state, state_nx;
  logic [BW-1:0]              beat;
  logic [SEED_W-1:0]          lfsr;
  logic [SEED_W:0]            scal;
  logic [W:0][SEED_W-1:0]     st;
  logic [SEED_W:0]            scal_eff;
  logic [W-1:0]               bind_bits;
  logic [W-1:0]               thr_bits;
  logic                       beat0, last_beat, fin_go, accept, out_xfer;

  assign beat0     = (beat == '0);
  assign last_beat = (beat == BW'(ROWS - 1));
  // Finalize only lands on a sample boundary; it wins over a coincident beat.
  assign fin_go    = (state == IDLE) && fin_req && beat0 && !rst;
  assign accept    = in_valid && in_ready;
  assign out_xfer  = (state == DRAIN) && out_ready;
  assign scal_eff  = beat0 ? in_scalar : scal;

  // Unrolled LFSR walk across the W positions of this beat, plus P ^ L bind.
  always_comb begin
    st[0] = beat0 ? cfg_seed : lfsr;
    for (int i = 0; i < W; i++) begin
      st[i+1] = {st[i][SEED_W-2:0], st[i][SEED_W-1] ^ st[i][5] ^ st[i][2] ^ st[i][1]};
    end
    for (int i = 0; i < W; i++) begin
      bind_bits[i] = (scal_eff > {1'b0, st[i]}) ^ in_level[i];
    end
  end

  genvar j;
  generate
    for (j = 0; j < W; j++) begin : g_lane
      hdc_lane #(.ROWS(ROWS), .CNT_W(CNT_W), .BW(BW)) u_lane (
        .clk     (clk),
        .rst     (rst),
        .row     (beat),
        .inc_en  (accept),
        .inc     (bind_bits[j]),
        .clr_en  (state == CLEAR),
        .thr     (n_samples >> 1),
        .bit_out (thr_bits[j])
      );
    end
  endgenerate

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (fin_go) state_nx = DRAIN;
      DRAIN:   if (out_xfer && last_beat) state_nx = CLEAR;
      CLEAR:   if (last_beat) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Handshake and output-stream decode.
  always_comb begin
    in_ready  = (state == IDLE) && !fin_go;
    fin_ack   = fin_go;
    out_valid = (state == DRAIN);
    out_last  = (state == DRAIN) && last_beat;
    out_data  = (state == DRAIN) ? thr_bits : '0;
    busy      = (state == DRAIN) || (state == CLEAR);
  end

  // Beat index, LFSR carry, latched scalar and sample count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat      <= '0;
      lfsr      <= '0;
      scal      <= '0;
      n_samples <= '0;
    end else if (accept) begin
      beat <= last_beat ? '0 : beat + BW'(1);
      lfsr <= st[W];
      if (beat0) scal <= in_scalar;
      if (last_beat && (n_samples != {CNT_W{1'b1}})) n_samples <= n_samples + CNT_W'(1);
    end else if (out_xfer) begin
      beat <= last_beat ? '0 : beat + BW'(1);
    end else if (state == CLEAR) begin
      beat <= last_beat ? '0 : beat + BW'(1);
      if (last_beat) n_samples <= '0;
    end
  end
endmodule
